// File: rtl/core_id_issue.sv
// -----------------------------------------------------------------------------
// core_id_issue
//
// ID-stage issue buffer in front of the EX unit. It holds one decoded
// instruction, owns the 32 x XLEN integer register file (x0 reads as zero)
// and resolves both source operands combinationally from the held register
// indices. An instruction whose source depends on an EX result that is not
// yet available is held back (valid_out low) until it can be resolved. An EX
// commit flush squashes the held entry and any instruction offered in the
// same cycle.
//
// Build option CORE_ID_FWD_EN:
//   defined   - operands may come from the EX forward path or the same-cycle
//               WB write; only an EX result that is not yet valid stalls.
//   undefined - operands come only from the register file (or zero); any
//               pending EX write or same-cycle WB write to a source stalls,
//               so the instruction issues the cycle after the write lands.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   valid_in/ready_in   decoder handshake into the buffer
//   i_*                 instruction fields captured on acceptance
//   valid_out/ready_out EX handshake out of the buffer
//   o_*                 registered instruction fields
//   o_rs1_dat/o_rs2_dat resolved source operands (combinational)
//   flush_req           EX commit flush
//   ex_fwd_*            state of the instruction currently held in EX
//   wb_en/wb_idx/wb_data register file write port
// -----------------------------------------------------------------------------
module core_id_issue #(
    parameter int XLEN    = 64,
    parameter int PC_W    = 64,
    parameter int RFIDX_W = 5,
    parameter int DEC_W   = 96
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    output logic               ready_in,
    input  logic [PC_W-1:0]    i_pc,
    input  logic               i_bp,
    input  logic               i_rs1_ren,
    input  logic               i_rs2_ren,
    input  logic [RFIDX_W-1:0] i_rs1_idx,
    input  logic [RFIDX_W-1:0] i_rs2_idx,
    input  logic               i_rd_wen,
    input  logic [RFIDX_W-1:0] i_rd_idx,
    input  logic [DEC_W-1:0]   i_dec_bus,
    output logic               valid_out,
    input  logic               ready_out,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_bp,
    output logic               o_rd_wen,
    output logic [RFIDX_W-1:0] o_rd_idx,
    output logic [RFIDX_W-1:0] o_rs1_idx,
    output logic [RFIDX_W-1:0] o_rs2_idx,
    output logic               o_rs1_ren,
    output logic               o_rs2_ren,
    output logic [DEC_W-1:0]   o_dec_bus,
    output logic [XLEN-1:0]    o_rs1_dat,
    output logic [XLEN-1:0]    o_rs2_dat,
    input  logic               flush_req,
    input  logic               ex_fwd_busy,
    input  logic               ex_fwd_wen,
    input  logic [RFIDX_W-1:0] ex_fwd_idx,
    input  logic               ex_fwd_dvld,
    input  logic [XLEN-1:0]    ex_fwd_dat,
    input  logic               wb_en,
    input  logic [RFIDX_W-1:0] wb_idx,
    input  logic [XLEN-1:0]    wb_data
);

    localparam int NREG = 1 << RFIDX_W;

    logic               vld_p0;
    logic [PC_W-1:0]    pc_p0;
    logic               bp_p0;
    logic               rd_wen_p0;
    logic [RFIDX_W-1:0] rd_idx_p0;
    logic [RFIDX_W-1:0] rs1_idx_p0;
    logic [RFIDX_W-1:0] rs2_idx_p0;
    logic               rs1_ren_p0;
    logic               rs2_ren_p0;
    logic [DEC_W-1:0]   dec_bus_p0;

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [XLEN-1:0]    rf [NREG];

    logic fire;
    logic load;
    logic stall;
    logic rs1_nz, rs2_nz;
    logic rs1_ex, rs2_ex;
    logic rs1_wb, rs2_wb;
    logic rs1_stall, rs2_stall;

    assign fire     = valid_out & ready_out;
    // A flush frees the slot for the decoder but the offered instruction is
    // dropped rather than loaded.
    assign ready_in = ~vld_p0 | fire | flush_req;
    assign load     = valid_in & ready_in & ~flush_req;

    // ---- Stage p0: issue buffer register (decoder -> EX) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            pc_p0      <= '0;
            bp_p0      <= 1'b0;
            rd_wen_p0  <= 1'b0;
            rd_idx_p0  <= '0;
            rs1_idx_p0 <= '0;
            rs2_idx_p0 <= '0;
            rs1_ren_p0 <= 1'b0;
            rs2_ren_p0 <= 1'b0;
            dec_bus_p0 <= '0;
        end else begin
            vld_p0 <= ~flush_req & (load | (vld_p0 & ~fire));
            if (load) begin
                pc_p0      <= i_pc;
                bp_p0      <= i_bp;
                rd_wen_p0  <= i_rd_wen;
                rd_idx_p0  <= i_rd_idx;
                rs1_idx_p0 <= i_rs1_idx;
                rs2_idx_p0 <= i_rs2_idx;
                rs1_ren_p0 <= i_rs1_ren;
                rs2_ren_p0 <= i_rs2_ren;
                dec_bus_p0 <= i_dec_bus;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && (wb_idx != '0)) begin
            rf[wb_idx] <= wb_data;
        end
    end

    assign rs1_nz = (rs1_idx_p0 != '0);
    assign rs2_nz = (rs2_idx_p0 != '0);
    assign rs1_ex = ex_fwd_busy & ex_fwd_wen & (ex_fwd_idx == rs1_idx_p0) & rs1_nz;
    assign rs2_ex = ex_fwd_busy & ex_fwd_wen & (ex_fwd_idx == rs2_idx_p0) & rs2_nz;
    assign rs1_wb = wb_en & (wb_idx == rs1_idx_p0) & rs1_nz;
    assign rs2_wb = wb_en & (wb_idx == rs2_idx_p0) & rs2_nz;

`ifdef CORE_ID_FWD_EN
    assign rs1_stall = rs1_ren_p0 & rs1_ex & ~ex_fwd_dvld;
    assign rs2_stall = rs2_ren_p0 & rs2_ex & ~ex_fwd_dvld;

    always_comb begin
        o_rs1_dat = '0;
        if (rs1_nz) begin
            if (rs1_ex)      o_rs1_dat = ex_fwd_dat;
            else if (rs1_wb) o_rs1_dat = wb_data;
            else             o_rs1_dat = rf[rs1_idx_p0];
        end
    end

    always_comb begin
        o_rs2_dat = '0;
        if (rs2_nz) begin
            if (rs2_ex)      o_rs2_dat = ex_fwd_dat;
            else if (rs2_wb) o_rs2_dat = wb_data;
            else             o_rs2_dat = rf[rs2_idx_p0];
        end
    end
`else
    // Without bypass the operand must wait until the write has landed in the
    // register file, so a same-cycle WB write counts as a hazard too.
    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd_dvld, ex_fwd_dat};

    assign rs1_stall = rs1_ren_p0 & (rs1_ex | rs1_wb);
    assign rs2_stall = rs2_ren_p0 & (rs2_ex | rs2_wb);
    assign o_rs1_dat = rs1_nz ? rf[rs1_idx_p0] : '0;
    assign o_rs2_dat = rs2_nz ? rf[rs2_idx_p0] : '0;
`endif

    assign stall     = rs1_stall | rs2_stall;
    assign valid_out = vld_p0 & ~stall & ~flush_req;

    assign o_pc      = pc_p0;
    assign o_bp      = bp_p0;
    assign o_rd_wen  = rd_wen_p0;
    assign o_rd_idx  = rd_idx_p0;
    assign o_rs1_idx = rs1_idx_p0;
    assign o_rs2_idx = rs2_idx_p0;
    assign o_rs1_ren = rs1_ren_p0;
    assign o_rs2_ren = rs2_ren_p0;
    assign o_dec_bus = dec_bus_p0;

endmodule

// File: tb/tb_core_id_issue.sv
// -----------------------------------------------------------------------------
// tb_core_id_issue
//
// Directed bench for core_id_issue: reset, throughput, EX forwarding / stall,
// WB bypass, backpressure and flush. Expected values are written inline for
// both the forwarding and the non-forwarding build.
// -----------------------------------------------------------------------------
module tb_core_id_issue;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         ready_in;
    logic [63:0]  i_pc;
    logic         i_bp;
    logic         i_rs1_ren, i_rs2_ren;
    logic [4:0]   i_rs1_idx, i_rs2_idx;
    logic         i_rd_wen;
    logic [4:0]   i_rd_idx;
    logic [95:0]  i_dec_bus;
    logic         valid_out;
    logic         ready_out;
    logic [63:0]  o_pc;
    logic         o_bp;
    logic         o_rd_wen;
    logic [4:0]   o_rd_idx, o_rs1_idx, o_rs2_idx;
    logic         o_rs1_ren, o_rs2_ren;
    logic [95:0]  o_dec_bus;
    logic [63:0]  o_rs1_dat, o_rs2_dat;
    logic         flush_req;
    logic         ex_fwd_busy, ex_fwd_wen, ex_fwd_dvld;
    logic [4:0]   ex_fwd_idx;
    logic [63:0]  ex_fwd_dat;
    logic         wb_en;
    logic [4:0]   wb_idx;
    logic [63:0]  wb_data;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    core_id_issue dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_in(ready_in),
        .i_pc(i_pc), .i_bp(i_bp),
        .i_rs1_ren(i_rs1_ren), .i_rs2_ren(i_rs2_ren),
        .i_rs1_idx(i_rs1_idx), .i_rs2_idx(i_rs2_idx),
        .i_rd_wen(i_rd_wen), .i_rd_idx(i_rd_idx),
        .i_dec_bus(i_dec_bus),
        .valid_out(valid_out), .ready_out(ready_out),
        .o_pc(o_pc), .o_bp(o_bp), .o_rd_wen(o_rd_wen), .o_rd_idx(o_rd_idx),
        .o_rs1_idx(o_rs1_idx), .o_rs2_idx(o_rs2_idx),
        .o_rs1_ren(o_rs1_ren), .o_rs2_ren(o_rs2_ren),
        .o_dec_bus(o_dec_bus),
        .o_rs1_dat(o_rs1_dat), .o_rs2_dat(o_rs2_dat),
        .flush_req(flush_req),
        .ex_fwd_busy(ex_fwd_busy), .ex_fwd_wen(ex_fwd_wen),
        .ex_fwd_idx(ex_fwd_idx), .ex_fwd_dvld(ex_fwd_dvld),
        .ex_fwd_dat(ex_fwd_dat),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [63:0] pc, input logic r1en, input logic [4:0] r1,
                         input logic r2en, input logic [4:0] r2);
        valid_in  = 1'b1;
        i_pc      = pc;
        i_bp      = pc[2];
        i_rs1_ren = r1en;
        i_rs1_idx = r1;
        i_rs2_ren = r2en;
        i_rs2_idx = r2;
        i_rd_wen  = 1'b1;
        i_rd_idx  = 5'd10;
        i_dec_bus = {32'hDEC0_0001, pc};
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0; i_pc = '0; i_bp = 1'b0;
        i_rs1_ren = 1'b0; i_rs2_ren = 1'b0; i_rs1_idx = '0; i_rs2_idx = '0;
        i_rd_wen = 1'b0; i_rd_idx = '0; i_dec_bus = '0;
        ready_out = 1'b0; flush_req = 1'b0;
        ex_fwd_busy = 1'b0; ex_fwd_wen = 1'b0; ex_fwd_idx = '0;
        ex_fwd_dvld = 1'b0; ex_fwd_dat = '0;
        wb_en = 1'b0; wb_idx = '0; wb_data = '0;

        // ---- reset ----
        #12;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_ready_in", ready_in, 1);
        chk("rst_o_pc", o_pc, 0);
        rst = 1'b0;
        tick();

        // ---- async reset mid-issue clears buffer and RF ----
        wb_en = 1'b1; wb_idx = 5'd5; wb_data = 64'h99;
        tick();
        wb_en = 1'b0;
        offer(64'h100, 1'b1, 5'd5, 1'b0, 5'd0);
        tick();
        valid_in = 1'b0;
        #1;
        chk("pre_rst_valid_out", valid_out, 1);
        chk("pre_rst_rs1_x5", o_rs1_dat, 64'h99);
        chk("pre_rst_o_pc", o_pc, 64'h100);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid_out", valid_out, 0);
        chk("mid_rst_ready_in", ready_in, 1);
        chk("mid_rst_o_pc", o_pc, 0);
        rst = 1'b0;
        tick();
        offer(64'h104, 1'b1, 5'd5, 1'b0, 5'd0);
        tick();
        valid_in = 1'b0;
        #1;
        chk("post_rst_rs1_x5", o_rs1_dat, 0);
        ready_out = 1'b1;
        tick();

        // ---- x0 reads zero even while being written ----
        ready_out = 1'b0;
        offer(64'h108, 1'b1, 5'd0, 1'b0, 5'd0);
        tick();
        valid_in = 1'b0;
        wb_en = 1'b1; wb_idx = 5'd0; wb_data = 64'h7;
        #1;
        chk("x0_same_cycle_dat", o_rs1_dat, 0);
        chk("x0_same_cycle_vld", valid_out, 1);
        tick();
        wb_en = 1'b0;
        #1;
        chk("x0_after_dat", o_rs1_dat, 0);
        ready_out = 1'b1;
        tick();

        // ---- throughput: 4 independent instructions back to back ----
        for (int i = 0; i < 4; i++) begin
            offer(64'(i * 4), 1'b0, 5'd0, 1'b0, 5'd0);
            tick();
            #1;
            chk("thru_valid_out", valid_out, 1);
            chk("thru_o_pc", o_pc, 64'(i * 4));
            chk("thru_ready_in", ready_in, 1);
        end
        chk("thru_dec_bus", o_dec_bus, {32'hDEC0_0001, 64'hC});
        chk("thru_rd_idx", o_rd_idx, 10);
        valid_in = 1'b0;
        tick();
        #1;
        chk("thru_drain", valid_out, 0);

        // ---- EX dependency on x3 ----
`ifdef CORE_ID_FWD_EN
        ex_fwd_busy = 1'b1; ex_fwd_wen = 1'b1; ex_fwd_idx = 5'd3;
        ex_fwd_dvld = 1'b1; ex_fwd_dat = 64'h55;
        ready_out = 1'b1;
        offer(64'h20, 1'b1, 5'd3, 1'b0, 5'd0);
        tick();
        offer(64'h24, 1'b1, 5'd3, 1'b0, 5'd0);
        #1;
        chk("fwd_valid_out", valid_out, 1);
        chk("fwd_rs1_dat", o_rs1_dat, 64'h55);
        chk("fwd_o_pc", o_pc, 64'h20);
        tick();
        valid_in = 1'b0;
        ex_fwd_dvld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fwd_stall_valid_out", valid_out, 0);
            chk("fwd_stall_ready_in", ready_in, 0);
            tick();
        end
        ex_fwd_dvld = 1'b1; ex_fwd_dat = 64'h77;
        #1;
        chk("fwd_release_valid_out", valid_out, 1);
        chk("fwd_release_rs1_dat", o_rs1_dat, 64'h77);
        chk("fwd_release_o_pc", o_pc, 64'h24);
        tick();
        ex_fwd_busy = 1'b0; ex_fwd_dvld = 1'b0;
`else
        ex_fwd_busy = 1'b1; ex_fwd_wen = 1'b1; ex_fwd_idx = 5'd3;
        ex_fwd_dvld = 1'b1; ex_fwd_dat = 64'h55;
        ready_out = 1'b1;
        offer(64'h20, 1'b1, 5'd3, 1'b0, 5'd0);
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nofwd_stall_valid_out", valid_out, 0);
            chk("nofwd_stall_ready_in", ready_in, 0);
            tick();
        end
        ex_fwd_busy = 1'b0; ex_fwd_dvld = 1'b0;
        wb_en = 1'b1; wb_idx = 5'd3; wb_data = 64'h55;
        #1;
        chk("nofwd_wb_stall", valid_out, 0);
        tick();
        wb_en = 1'b0;
        #1;
        chk("nofwd_release_valid_out", valid_out, 1);
        chk("nofwd_release_rs1_dat", o_rs1_dat, 64'h55);
        chk("nofwd_release_o_pc", o_pc, 64'h20);
        tick();
`endif
        #1;
        chk("dep_drain", valid_out, 0);

        // ---- WB write to x7 while it is being read ----
        ready_out = 1'b0;
        offer(64'h40, 1'b0, 5'd0, 1'b1, 5'd7);
        tick();
        valid_in = 1'b0;
        wb_en = 1'b1; wb_idx = 5'd7; wb_data = 64'h1234;
        #1;
`ifdef CORE_ID_FWD_EN
        chk("wb_bypass_valid_out", valid_out, 1);
        chk("wb_bypass_rs2_dat", o_rs2_dat, 64'h1234);
`else
        chk("wb_hazard_valid_out", valid_out, 0);
`endif
        tick();
        wb_en = 1'b0;
        #1;
        chk("wb_rf_rs2_dat", o_rs2_dat, 64'h1234);
        chk("wb_rf_valid_out", valid_out, 1);
        ready_out = 1'b1;
        tick();

        // ---- backpressure for 5 cycles ----
        ready_out = 1'b0;
        offer(64'h60, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        offer(64'h64, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready_in", ready_in, 0);
            chk("bp_o_pc", o_pc, 64'h60);
            chk("bp_valid_out", valid_out, 1);
            tick();
        end
        ready_out = 1'b1;
        #1;
        chk("bp_release_ready_in", ready_in, 1);
        tick();
        valid_in = 1'b0;
        #1;
        chk("bp_next_o_pc", o_pc, 64'h64);
        chk("bp_next_valid_out", valid_out, 1);
        tick();
        #1;
        chk("bp_drain", valid_out, 0);

        // ---- flush with held entry, new offer and concurrent WB ----
        ready_out = 1'b0;
        offer(64'h80, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        offer(64'h84, 1'b0, 5'd0, 1'b0, 5'd0);
        flush_req = 1'b1;
        wb_en = 1'b1; wb_idx = 5'd9; wb_data = 64'hA;
        ready_out = 1'b1;
        #1;
        chk("flush_valid_out", valid_out, 0);
        chk("flush_ready_in", ready_in, 1);
        tick();
        flush_req = 1'b0; valid_in = 1'b0; wb_en = 1'b0;
        #1;
        chk("flush_after_valid_out", valid_out, 0);
        chk("flush_after_ready_in", ready_in, 1);
        offer(64'h88, 1'b1, 5'd9, 1'b0, 5'd0);
        tick();
        valid_in = 1'b0;
        #1;
        chk("flush_wb_rs1_dat", o_rs1_dat, 64'hA);
        chk("flush_next_o_pc", o_pc, 64'h88);
        chk("flush_next_valid_out", valid_out, 1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
